// File: rtl/aidc_lite_collect_pkg.sv
// ---------------------------------------------------------------------------
// aidc_lite_collect_pkg
// Shared types and defaults for the AIDC-Lite decompression write collector.
//   state_e         : collector FSM state (IDLE / RUN / DRAIN / DONE)
//   DEF_*           : default parameter values for the collector top
//   rr_next()       : round-robin successor of a channel index
// ---------------------------------------------------------------------------
package aidc_lite_collect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_FIFO_DEPTH = 2;

    // Next round-robin position after granting channel 'cur' out of 'n'.
    function automatic int rr_next(input int cur, input int n);
        int nxt;
        if (cur >= n - 1) begin
            nxt = 0;
        end else begin
            nxt = cur + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/aidc_lite_ch_fifo.sv
// ---------------------------------------------------------------------------
// aidc_lite_ch_fifo
// Per-channel beat FIFO holding {addr, data} words from one decoder.
//   clk, rst      : clock, asynchronous active-high reset
//   flush_i       : empties the FIFO (wins over a same-cycle push/pop)
//   push_i        : write push_data_i (ignored when full)
//   pop_i         : drop head entry (ignored when empty)
//   pop_data_o    : current head entry (valid when !empty_o)
//   empty_o/full_o: occupancy flags, derived from registered pointers
// ---------------------------------------------------------------------------
module aidc_lite_ch_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    // Occupancy flags and next-pointer computation.
    always_comb begin
        empty_o   = (wr_ptr_q == rd_ptr_q);
        full_o    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        do_push_s = push_i && !full_o && !flush_i;
        do_pop_s  = pop_i && !empty_o && !flush_i;
        if (flush_i) begin
            wr_ptr_d = {(PW+1){1'b0}};
            rd_ptr_d = {(PW+1){1'b0}};
        end else begin
            wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_d = do_pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        end
        pop_data_o = mem_q[rd_ptr_q[PW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {(PW+1){1'b0}};
            rd_ptr_q <= {(PW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are meaningless while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/aidc_lite_decomp_collector.sv
// ---------------------------------------------------------------------------
// aidc_lite_decomp_collector
// Collects decoder writes through per-channel FIFOs and a round-robin
// arbiter into one line buffer, tracks per-entry valid bits, aggregates done
// pulses under a participation mask and flags overwrite/protocol errors.
//   start_i/ch_mask_i         : begin a block (also aborts a running one)
//   ch_valid_i/ch_ready_o     : per-channel handshake, ch_addr_i/ch_data_i packed
//   ch_done_i                 : per-channel end-of-block pulse
//   raddr_i -> rdata_o/rvalid_o : registered, read-first buffer read port
//   done_o                    : level, block complete and drained
//   err_o                     : sticky (overwrite or beat from unmasked channel)
//   fill_cnt_o                : distinct entries written since start
// ---------------------------------------------------------------------------
module aidc_lite_decomp_collector
    import aidc_lite_collect_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic [NUM_CH-1:0]              ch_mask_i,
    input  logic [NUM_CH-1:0]              ch_valid_i,
    output logic [NUM_CH-1:0]              ch_ready_o,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_addr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data_i,
    input  logic [NUM_CH-1:0]              ch_done_i,
    input  logic [ADDR_WIDTH-1:0]          raddr_i,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           rvalid_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic [ADDR_WIDTH:0]            fill_cnt_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int FW    = DATA_WIDTH + ADDR_WIDTH;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_WIDTH:0] FILL_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [NUM_CH-1:0]       mask_q, mask_d;
    logic [NUM_CH-1:0]       done_seen_q, done_seen_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH:0]     fill_q, fill_d;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   buf_mem [DEPTH];

    logic [NUM_CH-1:0]       ch_ready_s;
    logic [NUM_CH-1:0]       accept_s;
    logic [NUM_CH-1:0]       fifo_push_s;
    logic [NUM_CH-1:0]       fifo_pop_s;
    logic [NUM_CH-1:0]       fifo_empty_s;
    logic [NUM_CH-1:0]       fifo_full_s;
    logic [FW-1:0]           fifo_dout_s [NUM_CH];
    logic                    stray_s;
    logic                    grant_valid_s;
    logic [PTR_W-1:0]        grant_idx_s;
    logic                    pop_en_s;
    logic [FW-1:0]           wr_word_s;
    logic [ADDR_WIDTH-1:0]   wr_addr_s;
    logic [DATA_WIDTH-1:0]   wr_data_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        aidc_lite_ch_fifo #(
            .WIDTH (FW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .flush_i     (start_i),
            .push_i      (fifo_push_s[g]),
            .push_data_i ({ch_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH],
                           ch_data_i[g*DATA_WIDTH +: DATA_WIDTH]}),
            .pop_i       (fifo_pop_s[g]),
            .pop_data_o  (fifo_dout_s[g]),
            .empty_o     (fifo_empty_s[g]),
            .full_o      (fifo_full_s[g])
        );
    end

    // Handshake: only RUN accepts. Unmasked channels are accepted but never
    // pushed, so their FIFO stays empty and they keep ready high.
    always_comb begin
        if (state_q == ST_RUN) begin
            ch_ready_s = ~fifo_full_s;
        end else begin
            ch_ready_s = {NUM_CH{1'b0}};
        end
        accept_s    = ch_valid_i & ch_ready_s;
        fifo_push_s = accept_s & mask_q;
        stray_s     = |(accept_s & ~mask_q);
    end

    // Round-robin arbiter: first non-empty FIFO at or after rr_ptr_q.
    // No pop in a start cycle, since the FIFOs are being flushed.
    always_comb begin
        int idx;
        grant_valid_s = 1'b0;
        grant_idx_s   = rr_ptr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end else begin
                idx = idx;
            end
            if (!grant_valid_s && !fifo_empty_s[idx]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = PTR_W'(idx);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
        pop_en_s = grant_valid_s && !start_i;
        for (int k = 0; k < NUM_CH; k++) begin
            fifo_pop_s[k] = pop_en_s && (grant_idx_s == PTR_W'(k));
        end
        wr_word_s = fifo_dout_s[grant_idx_s];
        wr_addr_s = wr_word_s[FW-1 -: ADDR_WIDTH];
        wr_data_s = wr_word_s[DATA_WIDTH-1:0];
        if (pop_en_s) begin
            rr_ptr_d = PTR_W'(rr_next(int'(grant_idx_s), NUM_CH));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // FSM, valid bitmap, error and fill-count next-state logic.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        done_seen_d = done_seen_q;
        valid_d     = valid_q;
        err_d       = err_q;
        fill_d      = fill_q;
        if (start_i) begin
            state_d     = ST_RUN;
            mask_d      = ch_mask_i;
            done_seen_d = {NUM_CH{1'b0}};
            valid_d     = {DEPTH{1'b0}};
            err_d       = 1'b0;
            fill_d      = {(ADDR_WIDTH+1){1'b0}};
        end else begin
            if (pop_en_s) begin
                valid_d[wr_addr_s] = 1'b1;
                if (valid_q[wr_addr_s]) begin
                    err_d = 1'b1;
                end else begin
                    fill_d = fill_q + FILL_ONE;
                end
            end else begin
                fill_d = fill_q;
            end
            if (stray_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_d;
            end
            case (state_q)
                ST_RUN: begin
                    done_seen_d = done_seen_q | ch_done_i;
                    // Evaluated on the registered done set, so an empty mask
                    // leaves RUN at the end of its first cycle.
                    if ((done_seen_q & mask_q) == mask_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (&fifo_empty_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_IDLE:  state_d = ST_IDLE;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Control state, status outputs and registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= {NUM_CH{1'b0}};
            done_seen_q <= {NUM_CH{1'b0}};
            rr_ptr_q    <= {PTR_W{1'b0}};
            valid_q     <= {DEPTH{1'b0}};
            err_q       <= 1'b0;
            fill_q      <= {(ADDR_WIDTH+1){1'b0}};
            done_q      <= 1'b0;
            rdata_q     <= {DATA_WIDTH{1'b0}};
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            done_seen_q <= done_seen_d;
            rr_ptr_q    <= rr_ptr_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            fill_q      <= fill_d;
            done_q      <= (state_d == ST_DONE);
            // Old array/bitmap values are sampled, giving read-first behaviour.
            rdata_q     <= buf_mem[raddr_i];
            rvalid_q    <= valid_q[raddr_i];
        end
    end

    // Line buffer; stale contents are masked by the valid bitmap.
    always_ff @(posedge clk) begin
        if (pop_en_s) begin
            buf_mem[wr_addr_s] <= wr_data_s;
        end
    end

    assign ch_ready_o = ch_ready_s;
    assign rdata_o    = rdata_q;
    assign rvalid_o   = rvalid_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign fill_cnt_o = fill_q;

endmodule
